// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects the six raw
// board buttons {carry,chop,down,up,right,left} for game_logic.
// btn_level is the debounced level of each button. btn_pulse is a one-cycle
// strobe in the first cycle that a button's level is high.
// Optional feature macro: AUTO_REPEAT_EN. When it is defined, the four movement
// buttons (left/right/up/down) also emit auto-repeat pulses while held.
module button_conditioner #(
  parameter int NUM_BTNS        = 6,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int REPEAT_DELAY    = 26000000,
  parameter int REPEAT_PERIOD   = 9750000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTNS-1:0] sync1_q;
  logic [NUM_BTNS-1:0] sync2_q;
  logic [NUM_BTNS-1:0] level_q;
  logic [NUM_BTNS-1:0] level_d;
  logic [NUM_BTNS-1:0] pulse_q;
  logic [NUM_BTNS-1:0] pulse_d;
  logic [NUM_BTNS-1:0] press_s;
  logic [DW-1:0]       db_cnt_q [NUM_BTNS];
  logic [DW-1:0]       db_cnt_d [NUM_BTNS];

`ifdef AUTO_REPEAT_EN
  // Only the low four bits (left/right/up/down) get a repeat engine.
  localparam int NUM_MOVE = (NUM_BTNS < 4) ? NUM_BTNS : 4;
  localparam int RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW       = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_WAIT   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  rpt_state_e          rpt_state_q [NUM_MOVE];
  rpt_state_e          rpt_state_d [NUM_MOVE];
  logic [RW-1:0]       rpt_cnt_q   [NUM_MOVE];
  logic [RW-1:0]       rpt_cnt_d   [NUM_MOVE];
  logic [NUM_MOVE-1:0] rpt_pulse_s;

  // Saturating increment: the repeat counter must never wrap.
  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
    if (v == {RW{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + RW'(1);
    end
  endfunction
`else
  // Repeat timing is unused in this build; the parameters stay on the
  // interface so both builds share one instantiation.
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_params_unused
  end
`endif

  // Next-state logic: per-bit debounce, press detection and (optionally) repeat.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTNS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        // Mismatch has held long enough: accept the new level.
        level_d[i]  = ~level_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end

    press_s = level_d & ~level_q;
    pulse_d = press_s;

`ifdef AUTO_REPEAT_EN
    for (int i = 0; i < NUM_MOVE; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      rpt_pulse_s[i] = 1'b0;
      if (!level_d[i]) begin
        // Release aborts repeating in the same cycle, without a pulse.
        rpt_state_d[i] = RPT_IDLE;
        rpt_cnt_d[i]   = '0;
      end else begin
        case (rpt_state_q[i])
          RPT_IDLE: begin
            rpt_cnt_d[i] = '0;
            if (press_s[i]) begin
              rpt_state_d[i] = RPT_WAIT;
            end else begin
              rpt_state_d[i] = RPT_IDLE;
            end
          end
          RPT_WAIT: begin
            if (rpt_cnt_q[i] == RPT_DELAY_LAST) begin
              rpt_state_d[i] = RPT_REPEAT;
              rpt_cnt_d[i]   = '0;
              rpt_pulse_s[i] = 1'b1;
            end else begin
              rpt_cnt_d[i] = sat_inc(rpt_cnt_q[i]);
            end
          end
          RPT_REPEAT: begin
            if (rpt_cnt_q[i] == RPT_PERIOD_LAST) begin
              rpt_cnt_d[i]   = '0;
              rpt_pulse_s[i] = 1'b1;
            end else begin
              rpt_cnt_d[i] = sat_inc(rpt_cnt_q[i]);
            end
          end
          default: begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_cnt_d[i]   = '0;
          end
        endcase
      end
      pulse_d[i] = press_s[i] | rpt_pulse_s[i];
    end
`endif
  end

  // State registers: synchroniser, debounced levels, counters and output strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        db_cnt_q[i] <= '0;
      end
`ifdef AUTO_REPEAT_EN
      for (int i = 0; i < NUM_MOVE; i++) begin
        rpt_state_q[i] <= RPT_IDLE;
        rpt_cnt_q[i]   <= '0;
      end
`endif
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_BTNS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
`ifdef AUTO_REPEAT_EN
      for (int i = 0; i < NUM_MOVE; i++) begin
        rpt_state_q[i] <= rpt_state_d[i];
        rpt_cnt_q[i]   <= rpt_cnt_d[i];
      end
`endif
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short timing: debounce 4, repeat delay 8,
// repeat period 3. Behavioural model: a button's level flips after the synced
// pin has disagreed for 4 consecutive cycles; pulses come from the time held.
module tb_button_conditioner;

  localparam int NB  = 6;
  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RP  = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [NB-1:0] m_raw1, m_raw2, m_level, m_pulse;
  int            m_run  [NB];
  int            m_held [NB];

  button_conditioner #(
    .NUM_BTNS       (NB),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_raw1  = '0;
    m_raw2  = '0;
    m_level = '0;
    m_pulse = '0;
    for (int i = 0; i < NB; i++) begin
      m_run[i]  = 0;
      m_held[i] = 0;
    end
  endtask

  // One rising edge of the model; btn_raw is the value present before the edge.
  task automatic model_step();
    logic [NB-1:0] sv;
    logic          old_lvl;
    sv     = m_raw2;   // the debouncer sees the pin as it was two edges ago
    m_raw2 = m_raw1;
    m_raw1 = btn_raw;
    m_pulse = '0;
    for (int i = 0; i < NB; i++) begin
      old_lvl = m_level[i];
      if (sv[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_level[i] = sv[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      if (m_level[i] && !old_lvl) begin
        m_pulse[i] = 1'b1;
        m_held[i]  = 0;
      end else if (m_level[i]) begin
        m_held[i]++;
        if (RPT_EN && i < 4 && m_held[i] >= RD && ((m_held[i] - RD) % RP) == 0)
          m_pulse[i] = 1'b1;
      end
    end
  endtask

  // Drive raw at the falling edge, advance one clock, compare at the next falling edge.
  task automatic tick(input logic [NB-1:0] raw);
    btn_raw = raw;
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("level", btn_level, m_level);
    chk("pulse", btn_pulse, m_pulse);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_level", btn_level, 6'b000000);
    chk("rst_pulse", btn_pulse, 6'b000000);
    repeat (n) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic settle();
    for (int k = 0; k < 10; k++) tick(6'b000000);
  endtask

  typedef struct {
    logic [NB-1:0] raw;
    int            n;
    logic [NB-1:0] exp_level;
    logic [NB-1:0] exp_or;
    int            exp_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [NB-1:0] por;
    logic [NB-1:0] r;
    int pc;
    int pulse_at;

    vecs[0] = '{6'b000100, 7, 6'b000100, 6'b000100, 1};  // clean up press
    vecs[1] = '{6'b000000, 8, 6'b000000, 6'b000000, 0};  // release: no pulse
    vecs[2] = '{6'b100001, 7, 6'b100001, 6'b100001, 1};  // left+carry together
    vecs[3] = '{6'b000000, 8, 6'b000000, 6'b000000, 0};
    vecs[4] = '{6'b000010, 3, 6'b000000, 6'b000000, 0};  // 3-cycle glitch rejected
    vecs[5] = '{6'b000000, 8, 6'b000000, 6'b000000, 0};
    vecs[6] = '{6'b000010, 4, 6'b000000, 6'b000000, 0};  // 4 cycles: just accepted
    vecs[7] = '{6'b000000, 8, 6'b000000, 6'b000010, 1};
    vecs[8] = '{6'b111111, 7, 6'b111111, 6'b111111, 1};  // all at once
    vecs[9] = '{6'b000000, 8, 6'b000000, 6'b000000, 0};

    btn_raw = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_level", btn_level, 6'b000000);
    chk("reset_pulse", btn_pulse, 6'b000000);
    reset_n = 1'b1;

    // table-driven vectors
    for (int v = 0; v < 10; v++) begin
      por = '0;
      pc  = 0;
      for (int j = 0; j < vecs[v].n; j++) begin
        tick(vecs[v].raw);
        por = por | btn_pulse;
        if (btn_pulse != '0) pc++;
      end
      chk($sformatf("vec%0d_level", v), btn_level, vecs[v].exp_level);
      chk($sformatf("vec%0d_pulses", v), por, vecs[v].exp_or);
      chk_int($sformatf("vec%0d_pulse_cycles", v), pc, vecs[v].exp_cnt);
    end

    // bounce on chop, then held: exactly one pulse, 6 clocks after the last edge
    pc = 0;
    pulse_at = -1;
    for (int j = 1; j <= 42; j++) begin
      if (j <= 12) tick((((j - 1) / 2) % 2 == 0) ? 6'b010000 : 6'b000000);
      else         tick(6'b010000);
      if (btn_pulse[4]) begin
        pc++;
        pulse_at = j;
      end
    end
    chk_int("bounce_pulse_count", pc, 1);
    chk_int("bounce_pulse_time", pulse_at, 18);
    settle();

    // right held 30 clocks: press pulse at 6, repeats at 14,17,20,... when enabled
    for (int k = 1; k <= 30; k++) begin
      tick(6'b000010);
      chk($sformatf("repeat_k%0d", k), btn_pulse & 6'b000010,
          ((k == 6) || (RPT_EN && k >= 14 && ((k - 14) % 3) == 0)) ? 6'b000010 : 6'b000000);
    end
    for (int k = 0; k < 12; k++) tick(6'b000000);
    chk("repeat_released", btn_level, 6'b000000);

    // reset in the middle of a right press
    for (int k = 1; k <= 10; k++) tick(6'b000010);
    chk("pre_reset_level", btn_level, 6'b000010);
    do_reset(3);
    for (int k = 1; k <= 8; k++) begin
      tick(6'b000010);
      chk($sformatf("post_reset_k%0d", k), btn_pulse, (k == 6) ? 6'b000010 : 6'b000000);
    end
    settle();

    // randomized slow toggling against the model, with occasional resets
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, NB - 1)] ^= 1'b1;
      tick(r);
      if ($urandom_range(0, 499) == 0) do_reset(2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
